// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: feeds words MSB-first into the serial 1001/1110 detector and counts its hits.
// Build option SEQ_DET_CTRL_FLUSH_EN resets the detector for one cycle after every word.
module seq_det_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              det_in,
    output logic              det_rst_n,
    input  logic [3:0]        det_out,
    input  logic [CNT_W-1:0]  thresh,
    input  logic              clr,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic              word_done,
    output logic              irq
);

    localparam int IDX_W = $clog2(WORD_W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nx;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nx;
    logic              accept;
    logic              ready_nx;
    logic              drst_nx;
    logic              done_nx;
    logic              shifting;
    logic              hit_a;
    logic              hit_b;
    logic [CNT_W-1:0]  cnt_a_nx;
    logic [CNT_W-1:0]  cnt_b_nx;
    logic [CNT_W:0]    sum_nx;
    logic              irq_nx;

    assign accept   = s_valid && s_ready;
    assign shifting = (state == SHIFT);
    assign det_in   = shifting ? shreg[idx] : 1'b0;

    // Sequencing: load a word, walk the bit index down to zero, then idle, chain or flush.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        idx_nx   = idx;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nx = s_data;
                    idx_nx   = IDX_LAST;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (idx != '0) begin
                    idx_nx = idx - 1'b1;
                end else begin
                    done_nx = 1'b1;
`ifdef SEQ_DET_CTRL_FLUSH_EN
                    state_nx = FLUSH;
`else
                    if (accept) begin
                        shreg_nx = s_data;
                        idx_nx   = IDX_LAST;
                        state_nx = SHIFT;
                    end else begin
                        state_nx = IDLE;
                    end
`endif
                end
            end
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Ready is registered, so it is derived from where the FSM is heading.
`ifdef SEQ_DET_CTRL_FLUSH_EN
        ready_nx = (state_nx == IDLE);
        drst_nx  = (state_nx != FLUSH);
`else
        ready_nx = (state_nx == IDLE) || ((state_nx == SHIFT) && (idx_nx == '0));
        drst_nx  = 1'b1;
`endif
    end

    // Hit counting: clr wins over a simultaneous hit; counters stop at all-ones.
    always_comb begin
        hit_a    = shifting && (det_out == 4'h9);
        hit_b    = shifting && (det_out == 4'hE);
        cnt_a_nx = cnt_a;
        cnt_b_nx = cnt_b;
        if (clr) begin
            cnt_a_nx = '0;
            cnt_b_nx = '0;
        end else begin
            if (hit_a && (cnt_a != CNT_MAX)) cnt_a_nx = cnt_a + 1'b1;
            if (hit_b && (cnt_b != CNT_MAX)) cnt_b_nx = cnt_b + 1'b1;
        end
        sum_nx = {1'b0, cnt_a_nx} + {1'b0, cnt_b_nx};
        if (clr) begin
            irq_nx = 1'b0;
        end else begin
            irq_nx = irq || ((thresh != '0) && (sum_nx >= {1'b0, thresh}));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            s_ready   <= 1'b0;
            det_rst_n <= 1'b0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            word_done <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            idx       <= idx_nx;
            s_ready   <= ready_nx;
            det_rst_n <= drst_nx;
            cnt_a     <= cnt_a_nx;
            cnt_b     <= cnt_b_nx;
            word_done <= done_nx;
            irq       <= irq_nx;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: drives seq_det_ctrl with a stand-in Mealy 1001/1110 detector and a bit-queue reference.
// Honours SEQ_DET_CTRL_FLUSH_EN when the design is built with it.
module tb_seq_det_ctrl;

    localparam int WW    = 8;
    localparam int CW    = 8;
    localparam int MAXC  = 255;
`ifdef SEQ_DET_CTRL_FLUSH_EN
    localparam bit FLUSH_MODE = 1'b1;
`else
    localparam bit FLUSH_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready;
    logic          det_in;
    logic          det_rst_n;
    logic [3:0]    det_out;
    logic [CW-1:0] thresh = '0;
    logic          clr = 1'b0;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic          word_done;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.WORD_W(WW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .det_in(det_in), .det_rst_n(det_rst_n), .det_out(det_out), .thresh(thresh), .clr(clr),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .word_done(word_done), .irq(irq)
    );

    // Stand-in for the serial detector: three bits of history, Mealy match on the live bit.
    logic [2:0] det_hist;
    always_ff @(posedge clk) begin
        if (!det_rst_n) det_hist <= '0;
        else            det_hist <= {det_hist[1:0], det_in};
    end
    always_comb begin
        det_out = 4'h0;
        if ({det_hist, det_in} == 4'b1001)      det_out = 4'h9;
        else if ({det_hist, det_in} == 4'b1110) det_out = 4'hE;
    end

    // Reference: a queue of pending bits (bit, last-of-word); the front is what is on the wire.
    logic [1:0] mq[$];
    logic       m_ready = 1'b0, m_drst = 1'b0, m_wd = 1'b0, m_irq = 1'b0, m_flush = 1'b0, m_det_in = 1'b0;
    int         m_a = 0, m_b = 0;
    logic [2:0] m_hist = '0;
    logic       cur_shift, cur_bit, wd_now, acc_now;
    logic [3:0] win;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ready = 1'b0; m_drst = 1'b0; m_wd = 1'b0; m_irq = 1'b0; m_flush = 1'b0;
            m_a = 0; m_b = 0; m_hist = '0;
        end else begin
            cur_shift = (mq.size() != 0);
            cur_bit   = cur_shift ? mq[0][1] : 1'b0;
            win       = {m_hist, cur_bit};
            if (clr) begin
                m_a = 0; m_b = 0;
            end else begin
                if (cur_shift && win == 4'b1001 && m_a < MAXC) m_a = m_a + 1;
                if (cur_shift && win == 4'b1110 && m_b < MAXC) m_b = m_b + 1;
            end
            m_irq   = clr ? 1'b0 : (m_irq || (thresh != 0 && (m_a + m_b) >= int'(thresh)));
            acc_now = s_valid && m_ready;
            wd_now  = cur_shift && mq[0][0];
            if (cur_shift) void'(mq.pop_front());
            if (acc_now) for (int i = WW - 1; i >= 0; i--) mq.push_back({s_data[i], (i == 0)});
            m_hist  = m_drst ? {m_hist[1:0], cur_bit} : 3'b000;
            m_wd    = wd_now;
            m_flush = FLUSH_MODE && wd_now;
            m_ready = FLUSH_MODE ? (mq.size() == 0 && !m_flush) : (mq.size() <= 1);
            m_drst  = !m_flush;
        end
        m_det_in = (mq.size() != 0) ? mq[0][1] : 1'b0;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present a word and hold it until taken; returns on the negedge where its first bit is out.
    task automatic send_word(input logic [WW-1:0] w);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int n = 0; n < 40 && !ok; n++) begin
            ok = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL send_timeout: word %02h not accepted, required acceptance", w);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, det_rst_n, det_in, word_done, irq} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b required 00000", {s_ready, det_rst_n, det_in, word_done, irq});
        end
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_cnt: got a=%0d b=%0d required 0 0", cnt_a, cnt_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || det_rst_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release: got ready=%b drst=%b required 1 1", s_ready, det_rst_n);
        end
    endtask

    task automatic test_single_word();
        logic [WW-1:0] w = 8'h9E;
        int wd_count = 0;
        do_reset();
        thresh = '0;
        send_word(w);
        for (int k = 0; k < 12; k++) begin
            if (word_done) wd_count++;
            if (k < 8) begin
                checks++;
                if (det_in !== w[7-k]) begin
                    failures++;
                    $display("[TB] FAIL single_det_in[%0d]: got %b required %b", k, det_in, w[7-k]);
                end
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (int'(cnt_a) !== (k == 4 ? 1 : 0)) begin
                    failures++;
                    $display("[TB] FAIL single_cnt_a_k%0d: got %0d required %0d", k, cnt_a, (k == 4 ? 1 : 0));
                end
            end
            if (k == 8) begin
                checks++;
                if (word_done !== 1'b1 || cnt_b !== 8'd1) begin
                    failures++;
                    $display("[TB] FAIL single_done_b: got done=%b b=%0d required 1 1", word_done, cnt_b);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (wd_count != 1 || cnt_a !== 8'd1 || cnt_b !== 8'd1) begin
            failures++;
            $display("[TB] FAIL single_final: got done_pulses=%0d a=%0d b=%0d required 1 1 1", wd_count, cnt_a, cnt_b);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int drst_low = 0;
        bit got = 1'b0;
        do_reset();
        thresh = '0;
        send_word(8'h01);
        s_valid = 1'b1;
        s_data  = 8'h20;
        while (n < 30 && !got) begin
            if (!det_rst_n) drst_low++;
            if (n == 7) begin
                checks++;
                if (s_ready !== !FLUSH_MODE) begin
                    failures++;
                    $display("[TB] FAIL b2b_ready_last_bit: got %b required %b", s_ready, !FLUSH_MODE);
                end
            end
            got = s_ready;
            @(negedge clk);
            n++;
        end
        s_valid = 1'b0;
        checks++;
        if (n != (FLUSH_MODE ? 10 : 8)) begin
            failures++;
            $display("[TB] FAIL b2b_period: got %0d required %0d", n, (FLUSH_MODE ? 10 : 8));
        end
        checks++;
        if (drst_low != (FLUSH_MODE ? 1 : 0)) begin
            failures++;
            $display("[TB] FAIL b2b_det_rst_low: got %0d required %0d", drst_low, (FLUSH_MODE ? 1 : 0));
        end
        repeat (12) @(negedge clk);
        checks++;
        if (int'(cnt_a) !== (FLUSH_MODE ? 0 : 1) || int'(cnt_a) !== m_a) begin
            failures++;
            $display("[TB] FAIL b2b_cnt_a: got %0d required %0d", cnt_a, (FLUSH_MODE ? 0 : 1));
        end
    endtask

    task automatic test_threshold();
        int irq_seen = 0;
        do_reset();
        thresh = 8'd2;
        send_word(8'h9E);
        for (int k = 0; k < 12; k++) begin
            if (k == 7 || k == 8 || k == 11) begin
                checks++;
                if (irq !== (k != 7)) begin
                    failures++;
                    $display("[TB] FAIL thresh_irq_k%0d: got %b required %b", k, irq, (k != 7));
                end
            end
            @(negedge clk);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL thresh_clr: got a=%0d b=%0d irq=%b required 0 0 0", cnt_a, cnt_b, irq);
        end
        thresh = 8'd0;
        send_word(8'h9E);
        send_word(8'h9E);
        for (int k = 0; k < 12; k++) begin
            if (irq) irq_seen++;
            @(negedge clk);
        end
        checks++;
        if (irq_seen != 0 || int'(cnt_a) !== m_a || int'(cnt_b) !== m_b || cnt_a !== 8'd2) begin
            failures++;
            $display("[TB] FAIL thresh_zero: got irq_cycles=%0d a=%0d b=%0d required 0 %0d %0d", irq_seen, cnt_a, cnt_b, m_a, m_b);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        thresh = '0;
        for (int i = 0; i < 130; i++) send_word(8'h99);
        repeat (10) @(negedge clk);
        checks++;
        if (cnt_a !== 8'd255 || cnt_b !== 8'd0) begin
            failures++;
            $display("[TB] FAIL saturation: got a=%0d b=%0d required 255 0", cnt_a, cnt_b);
        end
    endtask

    task automatic test_reset_mid_word();
        int wd_count = 0;
        do_reset();
        thresh = '0;
        send_word(8'h9E);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({s_ready, det_rst_n, det_in, word_done, irq} !== 5'b0 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            failures++;
            $display("[TB] FAIL midrst_values: got flags=%b a=%0d b=%0d required 00000 0 0",
                     {s_ready, det_rst_n, det_in, word_done, irq}, cnt_a, cnt_b);
        end
        for (int k = 0; k < 10; k++) begin
            if (word_done) wd_count++;
            @(negedge clk);
        end
        checks++;
        if (wd_count != 0) begin
            failures++;
            $display("[TB] FAIL midrst_no_done: got %0d pulses required 0", wd_count);
        end
        send_word(8'h9E);
        repeat (10) @(negedge clk);
        checks++;
        if (cnt_a !== 8'd1 || cnt_b !== 8'd1) begin
            failures++;
            $display("[TB] FAIL midrst_fresh: got a=%0d b=%0d required 1 1", cnt_a, cnt_b);
        end
    endtask

    task automatic test_clr_collision();
        bit found = 1'b0;
        do_reset();
        thresh = '0;
        send_word(8'h9E);
        for (int k = 0; k < 12 && !found; k++) begin
            if (det_out == 4'h9) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL clr_hit_seen: got no 1001 match required one");
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd1) begin
            failures++;
            $display("[TB] FAIL clr_collision: got a=%0d b=%0d required 0 1", cnt_a, cnt_b);
        end
    endtask

    task automatic test_random();
        bit taken = 1'b0;
        do_reset();
        thresh = 8'($urandom_range(1, 12));
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (det_in !== m_det_in) begin
                failures++;
                $display("[TB] FAIL rand_det_in@%0d: got %b required %b", c, det_in, m_det_in);
            end
            checks++;
            if (s_ready !== m_ready) begin
                failures++;
                $display("[TB] FAIL rand_s_ready@%0d: got %b required %b", c, s_ready, m_ready);
            end
            checks++;
            if (det_rst_n !== m_drst) begin
                failures++;
                $display("[TB] FAIL rand_det_rst_n@%0d: got %b required %b", c, det_rst_n, m_drst);
            end
            checks++;
            if (word_done !== m_wd) begin
                failures++;
                $display("[TB] FAIL rand_word_done@%0d: got %b required %b", c, word_done, m_wd);
            end
            checks++;
            if (int'(cnt_a) !== m_a || int'(cnt_b) !== m_b) begin
                failures++;
                $display("[TB] FAIL rand_cnt@%0d: got a=%0d b=%0d required %0d %0d", c, cnt_a, cnt_b, m_a, m_b);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("[TB] FAIL rand_irq@%0d: got %b required %b", c, irq, m_irq);
            end
            clr = ($urandom_range(0, 39) == 0);
            if (!s_valid || taken) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 8'($urandom);
            end
            taken = s_valid && s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_threshold();
        test_saturation();
        test_reset_mid_word();
        test_clr_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
